// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage and IF/ID pipeline register for the
// 16-bit, 4-bit-opcode pipelined CPU.
//
// Owns the PC and the instruction memory read handshake. A miss parks fetch
// in a wait state until the fill completes. Decode can redirect fetch on a
// taken branch, and the hazard unit can stall. Fetch stops after a HLT is
// fetched, until a redirect or reset.
//
// Optional feature (macro FETCH_STALL_CNT_EN): adds a saturating 16-bit
// count of stalled fetch cycles on output fetch_stall_cnt.
//
// Ports:
//   clk              clock, all state updates on posedge
//   rst_n            synchronous active-low reset
//   stall            hazard-unit stall: hold PC and IF/ID
//   redirect_en      taken branch in decode: redirect fetch, squash IF/ID
//   redirect_pc      redirect target (bit 0 is forced to 0)
//   imem_rd_en       instruction read request
//   imem_addr        instruction read address
//   imem_data        instruction word, valid with imem_data_valid
//   imem_data_valid  hit in the same cycle, or miss-fill completion
//   ifid_instr       registered instruction to decode
//   ifid_pc_plus2    registered PC+2 of that instruction
//   ifid_valid       IF/ID holds a real instruction
//   pc               current fetch PC
//   halted           fetch stopped on HLT
//   fetch_stall_cnt  stalled-cycle count (only with FETCH_STALL_CNT_EN)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned     PC_W       = 16,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_rd_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            imem_data_valid,
    output logic [15:0]     ifid_instr,
    output logic [PC_W-1:0] ifid_pc_plus2,
    output logic            ifid_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]     fetch_stall_cnt
`endif
);

    localparam logic [1:0] StRun     = 2'd0;
    localparam logic [1:0] StWaitMem = 2'd1;
    localparam logic [1:0] StHalted  = 2'd2;

    logic [1:0]      stateQ, stateD;
    logic [PC_W-1:0] pcQ, pcD;
    logic [PC_W-1:0] missAddrQ, missAddrD;
    logic            redirectPendingQ, redirectPendingD;
    logic [15:0]     instrQ, instrD;
    logic [PC_W-1:0] pcPlus2Q, pcPlus2D;
    logic            validQ, validD;

    logic [PC_W-1:0] pcIncr;
    logic [PC_W-1:0] redirectTarget;
    logic            accept;
    logic            isHlt;

    assign pcIncr         = pcQ + PC_W'(2);
    assign redirectTarget = {redirect_pc[PC_W-1:1], 1'b0};
    assign isHlt          = (imem_data[15:12] == HLT_OPCODE);

    always_comb begin
        stateD           = stateQ;
        pcD              = pcQ;
        missAddrD        = missAddrQ;
        redirectPendingD = redirectPendingQ;
        instrD           = instrQ;
        pcPlus2D         = pcPlus2Q;
        validD           = validQ;
        accept           = 1'b0;

        case (stateQ)
            StRun: begin
                if (redirect_en) begin
                    pcD    = redirectTarget;
                    validD = 1'b0;
                end else if (stall) begin
                    // Hold everything; returned data is dropped.
                end else if (!imem_data_valid) begin
                    missAddrD = pcQ;
                    stateD    = StWaitMem;
                    validD    = 1'b0;
                end else begin
                    accept = 1'b1;
                end
            end
            StWaitMem: begin
                if (redirect_en) begin
                    pcD              = redirectTarget;
                    redirectPendingD = 1'b1;
                    validD           = 1'b0;
                    // A fill landing in the redirect cycle is old-path data: close the miss.
                    if (imem_data_valid) begin
                        redirectPendingD = 1'b0;
                        stateD           = StRun;
                    end
                end else if (imem_data_valid) begin
                    if (redirectPendingQ) begin
                        redirectPendingD = 1'b0;
                        stateD           = StRun;
                    end else if (stall) begin
                        // Drop the fill; the refetch from RUN should hit.
                        stateD = StRun;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            StHalted: begin
                if (redirect_en) begin
                    pcD    = redirectTarget;
                    validD = 1'b0;
                    stateD = StRun;
                end else if (!stall) begin
                    // HLT has been consumed by decode; issue it only once.
                    validD = 1'b0;
                end
            end
            default: begin
                stateD = StRun;
                validD = 1'b0;
            end
        endcase

        // In WAIT_MEM without a pending redirect pcQ still equals the miss address.
        if (accept) begin
            instrD   = imem_data;
            pcPlus2D = pcIncr;
            validD   = 1'b1;
            if (isHlt) begin
                stateD = StHalted;
            end else begin
                pcD    = pcIncr;
                stateD = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ           <= StRun;
            pcQ              <= RESET_PC;
            missAddrQ        <= '0;
            redirectPendingQ <= 1'b0;
            instrQ           <= 16'h0000;
            pcPlus2Q         <= '0;
            validQ           <= 1'b0;
        end else begin
            stateQ           <= stateD;
            pcQ              <= pcD;
            missAddrQ        <= missAddrD;
            redirectPendingQ <= redirectPendingD;
            instrQ           <= instrD;
            pcPlus2Q         <= pcPlus2D;
            validQ           <= validD;
        end
    end

    assign imem_rd_en    = (stateQ != StHalted);
    assign imem_addr     = (stateQ == StWaitMem) ? missAddrQ : pcQ;
    assign halted        = (stateQ == StHalted);
    assign pc            = pcQ;
    assign ifid_instr    = instrQ;
    assign ifid_pc_plus2 = pcPlus2Q;
    assign ifid_valid    = validQ;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stallCntQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCntQ <= 16'h0000;
        end else if (((stateQ == StWaitMem) || ((stateQ == StRun) && stall))
                     && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign fetch_stall_cnt = stallCntQ;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_data_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic [15:0] pc;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] fetch_stall_cnt;
`endif

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .imem_rd_en      (imem_rd_en),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .imem_data_valid (imem_data_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus2   (ifid_pc_plus2),
        .ifid_valid      (ifid_valid),
        .pc              (pc),
        .halted          (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatch = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: where fetch is (fetching / waiting on a fill / stopped),
    // what the PC is, and what sits in IF/ID.
    bit          mKnown = 0;
    bit          mWaiting, mStopped, mDropFill;
    logic [15:0] mPc, mFillAddr, mInstr, mPc2;
    bit          mValid;

    task automatic checkOutputs();
        if (!mKnown) return;
        checkVal("pc", {16'h0, pc}, {16'h0, mPc});
        checkVal("imem_rd_en", {31'h0, imem_rd_en}, {31'h0, !mStopped});
        checkVal("imem_addr", {16'h0, imem_addr}, {16'h0, mWaiting ? mFillAddr : mPc});
        checkVal("halted", {31'h0, halted}, {31'h0, mStopped});
        checkVal("ifid_valid", {31'h0, ifid_valid}, {31'h0, mValid});
        if (mValid) begin
            checkVal("ifid_instr", {16'h0, ifid_instr}, {16'h0, mInstr});
            checkVal("ifid_pc_plus2", {16'h0, ifid_pc_plus2}, {16'h0, mPc2});
        end
    endtask

    task automatic takeInstr(input logic [15:0] d);
        mInstr   = d;
        mPc2     = mPc + 16'd2;
        mValid   = 1;
        mWaiting = 0;
        if (d[15:12] == 4'hF) mStopped = 1;
        else mPc = mPc + 16'd2;
    endtask

    task automatic modelStep(input bit rst, input bit st, input bit re, input logic [15:0] rpc,
                             input bit dv, input logic [15:0] d);
        logic [15:0] tgt;
        tgt = rpc & 16'hFFFE;
        if (!rst) begin
            mKnown = 1; mWaiting = 0; mStopped = 0; mDropFill = 0;
            mPc = 16'h0000; mFillAddr = 0; mInstr = 0; mPc2 = 0; mValid = 0;
        end else if (mStopped) begin
            if (re) begin
                mPc = tgt; mValid = 0; mStopped = 0;
            end else if (!st) begin
                mValid = 0;
            end
        end else if (mWaiting) begin
            if (re) begin
                mPc = tgt; mDropFill = 1; mValid = 0;
            end else if (dv) begin
                if (mDropFill) begin
                    mDropFill = 0; mWaiting = 0;
                end else if (st) begin
                    mWaiting = 0;
                end else begin
                    takeInstr(d);
                end
            end
        end else begin
            if (re) begin
                mPc = tgt; mValid = 0;
            end else if (st) begin
                // held
            end else if (!dv) begin
                mFillAddr = mPc; mWaiting = 1; mValid = 0;
            end else begin
                takeInstr(d);
            end
        end
    endtask

    // One clock: check current outputs, apply inputs, advance model and DUT.
    task automatic tick(input bit rst, input bit st, input bit re, input logic [15:0] rpc,
                        input bit dv, input logic [15:0] d);
        checkOutputs();
        rst_n           = rst;
        stall           = st;
        redirect_en     = re;
        redirect_pc     = rpc;
        imem_data_valid = dv;
        imem_data       = d;
        modelStep(rst, st, re, rpc, dv, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hit(input logic [15:0] d);
        tick(1, 0, 0, 16'h0, 1, d);
    endtask

    task automatic miss();
        tick(1, 0, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic redir(input logic [15:0] rpc);
        tick(1, 0, 1, rpc, 0, 16'h0);
    endtask

    initial begin
        logic [15:0] hits [4];
        bit st, re, dv, rst;
        logic [15:0] rpc, d;
        hits[0] = 16'h1123; hits[1] = 16'h2456; hits[2] = 16'h0789; hits[3] = 16'h3ABC;

        rst_n = 0; stall = 0; redirect_en = 0; redirect_pc = 0;
        imem_data_valid = 0; imem_data = 0;
        @(negedge clk);
        tick(0, 0, 0, 16'h0, 0, 16'h0);
        tick(0, 1, 1, 16'h1234, 1, 16'hF000);
        checkOutputs();
        checkVal("reset_pc", {16'h0, pc}, 32'h0);
        checkVal("reset_valid", {31'h0, ifid_valid}, 32'h0);
        checkVal("reset_instr", {16'h0, ifid_instr}, 32'h0);

        // Four hits back to back.
        for (int i = 0; i < 4; i++) hit(hits[i]);
        checkVal("hits_pc", {16'h0, pc}, 32'h8);
        checkVal("hits_pc2", {16'h0, ifid_pc_plus2}, 32'h8);
        checkVal("hits_instr", {16'h0, ifid_instr}, 32'h3ABC);

        // Miss at pc=4, fill after 3 cycles.
        redir(16'h0004);
        miss();
        miss();
        checkVal("miss_addr", {16'h0, imem_addr}, 32'h4);
        checkVal("miss_valid", {31'h0, ifid_valid}, 32'h0);
        miss();
        tick(1, 0, 0, 16'h0, 1, 16'h4321);
        checkVal("fill_instr", {16'h0, ifid_instr}, 32'h4321);
        checkVal("fill_pc2", {16'h0, ifid_pc_plus2}, 32'h6);
        checkVal("fill_pc", {16'h0, pc}, 32'h6);

        // Redirect during a miss.
        miss();
        miss();
        tick(1, 0, 1, 16'h0041, 0, 16'h0);
        tick(1, 0, 0, 16'h0, 1, 16'h5555);
        checkVal("redir_miss_addr", {16'h0, imem_addr}, 32'h40);
        checkVal("redir_miss_valid", {31'h0, ifid_valid}, 32'h0);
        hit(16'h1111);
        checkVal("redir_miss_pc2", {16'h0, ifid_pc_plus2}, 32'h42);

        // Stall and redirect together: redirect wins.
        tick(1, 1, 1, 16'h0100, 1, 16'h2222);
        checkVal("stall_redir_pc", {16'h0, pc}, 32'h100);
        checkVal("stall_redir_valid", {31'h0, ifid_valid}, 32'h0);

        // HLT at 0x0010, then redirect out.
        redir(16'h0010);
        hit(16'hF000);
        checkVal("hlt_halted", {31'h0, halted}, 32'h1);
        checkVal("hlt_rd_en", {31'h0, imem_rd_en}, 32'h0);
        checkVal("hlt_pc", {16'h0, pc}, 32'h10);
        checkVal("hlt_valid", {31'h0, ifid_valid}, 32'h1);
        hit(16'h3333);
        checkVal("hlt_once", {31'h0, ifid_valid}, 32'h0);
        redir(16'h0020);
        checkVal("unhalt", {31'h0, halted}, 32'h0);
        checkVal("unhalt_addr", {16'h0, imem_addr}, 32'h20);

        // PC wrap.
        redir(16'hFFFE);
        hit(16'h1000);
        checkVal("wrap_pc", {16'h0, pc}, 32'h0);
        checkVal("wrap_pc2", {16'h0, ifid_pc_plus2}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            st  = ($urandom_range(0, 4) == 0);
            re  = ($urandom_range(0, 9) == 0);
            dv  = ($urandom_range(0, 3) != 0);
            rpc = 16'($urandom);
            d   = 16'($urandom);
            // Keep a fill and a redirect from landing in the same waiting cycle.
            if (mWaiting && re) dv = 0;
            tick(rst, st, re, rpc, dv, d);
        end
        checkOutputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
